// File: rtl/apb_pkg.sv
// Shared state encoding, command record and default widths for the APB requester.
package apb_pkg;

  localparam int unsigned addr_width_dflt = 32;
  localparam int unsigned data_width_dflt = 32;
  localparam int unsigned timeout_dflt    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                       write;
    logic [addr_width_dflt-1:0] addr;
    logic [data_width_dflt-1:0] wdata;
  } apb_cmd_t;

  // A disabled timer (limit 0) still needs a 1-bit counter to stay legal.
  function automatic int unsigned timer_width(input int unsigned limit);
    return (limit > 0) ? $clog2(limit + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_req_master_if.sv
// Command/response handshake plus APB bus signals between requester and slave side.
interface apb_req_master_if
  import apb_pkg::*;
#(
  parameter int unsigned addr_width = addr_width_dflt,
  parameter int unsigned data_width = data_width_dflt
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [data_width-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_write;
  logic [data_width-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [addr_width-1:0] paddr;
  logic [data_width-1:0] pwdata;
  logic                  pwrite;
  logic                  pselx;
  logic                  penable;
  logic                  ptransfer;
  logic                  pslave_error;
  logic                  pready;
  logic [data_width-1:0] prdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           paddr, pwdata, pwrite, pselx, penable, ptransfer, pslave_error
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
           paddr, pwdata, pwrite, pselx, penable, ptransfer, pslave_error
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Saturating wait-state counter; expired flags the last ACCESS cycle allowed without pready.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned limit = timeout_dflt
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int unsigned cnt_w = timer_width(limit);

  logic [cnt_w-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (limit == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = (cnt_q == cnt_w'(limit - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_req_master.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS sequences with timeout abort.
//   state  | meaning
//   IDLE   | bus idle, ready for a command
//   SETUP  | pselx high for one cycle, penable low
//   ACCESS | pselx+penable high until pready or timeout
module apb_req_master
  import apb_pkg::*;
#(
  parameter int unsigned addr_width     = addr_width_dflt,
  parameter int unsigned data_width     = data_width_dflt,
  parameter int unsigned timeout_cycles = timeout_dflt
) (
  input logic               pclk,
  input logic               preset,
  apb_req_master_if.master  bus
);
  typedef struct packed {
    logic                  write;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] wdata;
  } cmd_t;

  apb_state_e            state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  pselx_q, pselx_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [data_width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  perr_q, perr_d;
  logic                  accept;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  expired;

  assign bus.cmd_ready = (state_q == IDLE) || ((state_q == ACCESS) && bus.pready);
  assign bus.ptransfer = (state_q == ACCESS) && bus.cmd_valid;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    perr_d      = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) state_d = SETUP;
      end
      SETUP: begin
        timer_clear = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over a timeout landing in the same cycle
        if (bus.pready) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_rdata_d = cmd_q.write ? '0 : bus.prdata;
          state_d     = bus.cmd_valid ? SETUP : IDLE;
        end else if (expired) begin
          rsp_valid_d = 1'b1;
          rsp_write_d = cmd_q.write;
          rsp_err_d   = 1'b1;
          perr_d      = 1'b1;
          state_d     = IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      cmd_d.write = bus.cmd_write;
      cmd_d.addr  = bus.cmd_addr;
      cmd_d.wdata = bus.cmd_wdata;
    end
    pselx_d   = (state_d != IDLE);
    penable_d = (state_d == ACCESS);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      perr_q      <= perr_d;
    end
  end

  apb_wait_timer #(.limit(timeout_cycles)) u_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  assign bus.paddr        = cmd_q.addr;
  assign bus.pwdata       = cmd_q.wdata;
  assign bus.pwrite       = cmd_q.write;
  assign bus.pselx        = pselx_q;
  assign bus.penable      = penable_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_write    = rsp_write_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.pslave_error = perr_q;

endmodule

// File: tb/tb_apb_req_master.sv
// Scoreboard bench for apb_req_master: one instance with a 16-cycle timeout, one with 4.
module tb_apb_req_master;

  typedef struct {
    logic        write;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic pclk;
  logic preset;

  apb_req_master_if #(.addr_width(32), .data_width(32)) c16 ();
  apb_req_master_if #(.addr_width(32), .data_width(32)) c4 ();

  apb_req_master #(.addr_width(32), .data_width(32), .timeout_cycles(16)) dut16 (
    .pclk   (pclk),
    .preset (preset),
    .bus    (c16)
  );

  apb_req_master #(.addr_width(32), .data_width(32), .timeout_cycles(4)) dut4 (
    .pclk   (pclk),
    .preset (preset),
    .bus    (c4)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb16[$];
  exp_t        sb4[$];
  logic [31:0] mem [256];
  int          wait_req = 0;
  int          acc_cnt = 0;
  logic        obs_en = 1'b0;
  logic        pt_log[$];
  int          idle_seen = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Slave for the 16-cycle instance: pready after wait_req ACCESS cycles; writes commit then.
  initial forever begin
    @(negedge pclk);
    if (c16.pselx && c16.penable) begin
      c16.pready = (acc_cnt >= wait_req);
      c16.prdata = mem[c16.paddr[7:0]];
      if (c16.pready && c16.pwrite) mem[c16.paddr[7:0]] = c16.pwdata;
      acc_cnt++;
    end else begin
      c16.pready = 1'b0;
      c16.prdata = '0;
      acc_cnt = 0;
    end
  end

  initial forever begin
    @(negedge pclk);
    #1;
    if (obs_en && c16.pselx && c16.penable) pt_log.push_back(c16.ptransfer);
    if (obs_en && !c16.pselx) idle_seen++;
  end

  initial forever begin
    exp_t e;
    @(negedge pclk);
    if (c16.rsp_valid) begin
      if (sb16.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp16_unexpected: got rsp_valid=1, required no response");
      end else begin
        e = sb16.pop_front();
        chk_b("rsp16_write", c16.rsp_write, e.write);
        chk_w("rsp16_rdata", c16.rsp_rdata, e.rdata);
        chk_b("rsp16_err", c16.rsp_err, e.err);
      end
    end
    if (c4.rsp_valid) begin
      if (sb4.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rsp4_unexpected: got rsp_valid=1, required no response");
      end else begin
        e = sb4.pop_front();
        chk_b("rsp4_write", c4.rsp_write, e.write);
        chk_w("rsp4_rdata", c4.rsp_rdata, e.rdata);
        chk_b("rsp4_err", c4.rsp_err, e.err);
      end
    end
  end

  task automatic issue16(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_rsp, input logic [31:0] exp_rdata);
    int n = 0;
    if (exp_rsp) sb16.push_back('{w, exp_rdata, 1'b0});
    c16.cmd_valid = 1'b1;
    c16.cmd_write = w;
    c16.cmd_addr  = a;
    c16.cmd_wdata = d;
    #1;
    while (!c16.cmd_ready && n < 100) begin
      @(negedge pclk);
      #1;
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_accept: cmd_ready stayed 0, required 1");
    end
    @(negedge pclk);
    c16.cmd_valid = 1'b0;
  endtask

  initial begin
    int acc;
    int n;
    c16.cmd_valid = 1'b0;
    c16.cmd_write = 1'b0;
    c16.cmd_addr  = '0;
    c16.cmd_wdata = '0;
    c4.cmd_valid  = 1'b0;
    c4.cmd_write  = 1'b0;
    c4.cmd_addr   = '0;
    c4.cmd_wdata  = '0;
    c4.pready     = 1'b0;
    c4.prdata     = 32'hA5A5_A5A5;
    preset        = 1'b1;
    repeat (3) @(negedge pclk);

    chk_b("rst_pselx", c16.pselx, 1'b0);
    chk_b("rst_penable", c16.penable, 1'b0);
    chk_b("rst_rsp_valid", c16.rsp_valid, 1'b0);
    chk_w("rst_paddr", c16.paddr, 32'h0);
    chk_b("rst_cmd_ready", c16.cmd_ready, 1'b1);
    preset = 1'b0;
    @(negedge pclk);

    // Zero-wait write: SETUP, ACCESS, response on the third cycle
    issue16(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'h0);
    chk_b("wr_setup_pselx", c16.pselx, 1'b1);
    chk_b("wr_setup_penable", c16.penable, 1'b0);
    chk_b("wr_setup_pwrite", c16.pwrite, 1'b1);
    chk_w("wr_setup_paddr", c16.paddr, 32'h10);
    chk_w("wr_setup_pwdata", c16.pwdata, 32'hDEAD_BEEF);
    @(negedge pclk);
    chk_b("wr_access_penable", c16.penable, 1'b1);
    chk_b("wr_access_no_rsp", c16.rsp_valid, 1'b0);
    @(negedge pclk);
    chk_b("wr_rsp_latency", c16.rsp_valid, 1'b1);
    chk_b("wr_back_idle", c16.pselx, 1'b0);

    issue16(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk_b("rd_setup_pwrite", c16.pwrite, 1'b0);
    @(negedge pclk);
    chk_b("rd_access_pwrite", c16.pwrite, 1'b0);
    @(negedge pclk);

    // Five wait states: six ACCESS cycles with stable address/enable
    wait_req = 5;
    issue16(1'b1, 32'h20, 32'h1234_5678, 1'b1, 32'h0);
    acc = 0;
    n = 0;
    while (!c16.rsp_valid && n < 40) begin
      @(negedge pclk);
      if (c16.penable) begin
        acc++;
        chk_w("wait_paddr_stable", c16.paddr, 32'h20);
        chk_b("wait_pselx_stable", c16.pselx, 1'b1);
      end
      n++;
    end
    chk_w("wait_access_cycles", 32'(acc), 32'd6);
    wait_req = 0;
    @(negedge pclk);

    // Slave never answers on the 4-cycle instance: abort after 4 ACCESS cycles
    sb4.push_back('{1'b0, 32'h0, 1'b1});
    c4.cmd_valid = 1'b1;
    c4.cmd_write = 1'b0;
    c4.cmd_addr  = 32'h30;
    #1;
    chk_b("to_cmd_ready", c4.cmd_ready, 1'b1);
    @(negedge pclk);
    c4.cmd_valid = 1'b0;
    acc = 0;
    n = 0;
    while (!c4.rsp_valid && n < 40) begin
      @(negedge pclk);
      if (c4.penable) acc++;
      n++;
    end
    chk_w("to_access_cycles", 32'(acc), 32'd4);
    chk_b("to_pslave_error", c4.pslave_error, 1'b1);
    chk_b("to_pselx_low", c4.pselx, 1'b0);
    @(negedge pclk);
    chk_b("to_perr_pulse_end", c4.pslave_error, 1'b0);
    chk_b("to_rsp_pulse_end", c4.rsp_valid, 1'b0);

    // Three chained commands with cmd_valid held
    issue16(1'b1, 32'h40, 32'h1111_1111, 1'b1, 32'h0);
    obs_en = 1'b1;
    issue16(1'b1, 32'h44, 32'h2222_2222, 1'b1, 32'h0);
    issue16(1'b0, 32'h40, 32'h0, 1'b1, 32'h1111_1111);
    @(negedge pclk);
    @(negedge pclk);
    obs_en = 1'b0;
    chk_w("chain_access_count", 32'(pt_log.size()), 32'd3);
    if (pt_log.size() == 3) begin
      chk_b("chain_ptransfer0", pt_log[0], 1'b1);
      chk_b("chain_ptransfer1", pt_log[1], 1'b1);
      chk_b("chain_ptransfer2", pt_log[2], 1'b0);
    end
    chk_w("chain_no_idle", 32'(idle_seen), 32'd0);
    @(negedge pclk);

    // Reset in the middle of ACCESS drops the transfer
    wait_req = 1000;
    issue16(1'b1, 32'h50, 32'hCAFE_F00D, 1'b0, 32'h0);
    @(negedge pclk);
    chk_b("rst_mid_in_access", c16.penable, 1'b1);
    #2;
    preset = 1'b1;
    #1;
    chk_b("rst_mid_pselx", c16.pselx, 1'b0);
    chk_b("rst_mid_penable", c16.penable, 1'b0);
    chk_w("rst_mid_paddr", c16.paddr, 32'h0);
    chk_w("rst_mid_pwdata", c16.pwdata, 32'h0);
    chk_b("rst_mid_pwrite", c16.pwrite, 1'b0);
    chk_b("rst_mid_rsp_valid", c16.rsp_valid, 1'b0);
    chk_b("rst_mid_perr", c16.pslave_error, 1'b0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b0;
    wait_req = 0;
    @(negedge pclk);
    issue16(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
    repeat (5) @(negedge pclk);

    chk_w("sb16_drained", 32'(sb16.size()), 32'd0);
    chk_w("sb4_drained", 32'(sb4.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
